mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Fixed-latency word memory for the multicycle controller: one request at a time,
// completed with a single ready strobe WAIT_CYCLES edges after acceptance.
module mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ready_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                wr_q, wr_d;
   logic                both_q, both_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                complete_s;
   logic                req_err_s;
   logic [DEPTH_LOG2-1:0] idx_s;

   logic [31:0]         mem_q [DEPTH];

   // Errors are judged on the latched request, never on the live inputs.
   assign req_err_s = (addr_q[1:0] != 2'b00) ||
                      ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0) ||
                      both_q;
   assign idx_s     = addr_q[DEPTH_LOG2+1:2];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      both_d     = both_q;
      complete_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_read_i || mem_write_i) begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_LOAD;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               wr_d    = mem_write_i;
               both_d  = mem_read_i && mem_write_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d    = ST_RESP;
               cnt_d      = 4'd0;
               complete_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      ready_d = complete_s;
      err_d   = complete_s && req_err_s;
      busy_d  = (state_d != ST_IDLE);
      if (complete_s && !req_err_s && !wr_q) begin
         rdata_d = mem_q[idx_s];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Control and output registers; reset aborts any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wr_q    <= 1'b0;
         both_q  <= 1'b0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         both_q  <= both_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Storage keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (complete_s && !req_err_s && wr_q) begin
         mem_q[idx_s] <= wdata_q;
      end
   end

   assign rdata_o = rdata_q;
   assign ready_o = ready_q;
   assign err_o   = err_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a word-array reference model.
module tb_mem_responder;

   localparam int W  = 2;
   localparam int DL = 8;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        ready, err, busy;

   int          checks = 0;
   int          fails  = 0;
   int          cyc    = 0;
   exp_t        sb[$];
   logic [31:0] mem_m [1 << DL];
   logic [31:0] last_rd;

   mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
      .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready),
      .err_o(err), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ready strobe pops one expectation; err must stay low otherwise.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (ready) begin
            if (sb.size() == 0) begin
               chk("spurious_ready", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("err", {31'd0, err}, {31'd0, e.err});
               chk("rdata", rdata, e.rdata);
               chk("latency_cycle", cyc, e.cyc);
            end
         end else begin
            chk("err_without_ready", {31'd0, err}, 32'd0);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   function automatic logic model_err(input logic rd, input logic wr, input logic [31:0] a);
      logic [1:0] lo;
      lo = a[1:0];
      return (lo != 2'd0) || ((a >> (DL + 2)) != 32'd0) || (rd && wr);
   endfunction

   task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input bit poke);
      exp_t e;
      wait_idle();
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      wdata     = d;
      e.err = model_err(rd, wr, a);
      e.cyc = cyc + 1 + W;
      if (!e.err && wr) mem_m[a[DL+1:2]] = d;
      if (!e.err && !wr) last_rd = mem_m[a[DL+1:2]];
      e.rdata = last_rd;
      sb.push_back(e);
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      if (poke) begin
         mem_read  = 1'($urandom_range(0, 1));
         mem_write = ~mem_read;
         addr      = {22'd0, 8'($urandom), 2'd0};
         wdata     = $urandom;
         @(negedge clk);
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
      last_rd = 32'd0;
      #12;
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < (1 << DL); i++) req(1'b0, 1'b1, i * 4, $urandom, 1'b0);

      req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
      req(1'b0, 1'b1, 32'h400, 32'h12345678, 1'b0);
      req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      req(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b1);
      req(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      req(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
      req(1'b1, 1'b0, 32'h8, 32'h0, 1'b1);

      // Reset one cycle into a write to 0x20: request aborted, nothing written.
      wait_idle();
      mem_read = 1'b0; mem_write = 1'b1; addr = 32'h20; wdata = 32'h0BADF00D;
      @(posedge clk);
      @(negedge clk);
      mem_write = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, ready}, 32'd0);
      chk("abort_rdata", rdata, 32'd0);
      last_rd = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 9);
         if (k < 6)      a = {22'd0, 8'($urandom), 2'd0};
         else if (k < 8) a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
         else            a = $urandom | 32'h400;
         k = $urandom_range(0, 9);
         req(k < 5, (k >= 5 && k < 9) || k == 9, a, $urandom, $urandom_range(0, 3) == 0);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
